// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, per-stage
// enable/flush bundle and the default divider latency.
package hazard_ctrl_pkg;

  localparam int unsigned DIV_LAT_DEF = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV      = 2'd1,
    DIV_HOLD = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } en_vec_t;

  typedef struct packed {
    logic d;
    logic e;
    logic m;
    logic w;
  } flush_vec_t;

  typedef struct packed {
    en_vec_t    en;
    flush_vec_t flush;
  } pipe_ctl_t;

endpackage

// File: rtl/hazard_ctrl_div_timer.sv
// Divider occupancy counter: load to DIV_LAT-1, count down to zero, never wrap.
// park flags a count that has run out while the pipe is frozen.
module div_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic count,
  input  logic freeze,
  output logic zero,
  output logic park
);

  localparam int unsigned CW = $clog2(DIV_LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);
  assign park = count & freeze & zero;

endmodule

// File: rtl/hazard_ctrl.sv
// Central five-stage pipeline control: per-stage enable/flush from hazards.
// Optional performance counters built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic             e_load,
  input  logic [REG_W-1:0] e_rd,
  input  logic             e_div,
  input  logic             e_redirect,
  input  logic             m_exc,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             div_done,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_div
);

  hz_state_t state;
  pipe_ctl_t ctl;
  logic      zero, park;
  logic      load_use, div_start, exc_take;

  assign exc_take  = ~d_stall & m_exc;
  assign div_start = ~d_stall & ~m_exc & (state == RUN) & e_div;
  assign load_use  = e_load & d_valid & (e_rd != '0) &
                     ((e_rd == d_rs1) | (e_rd == d_rs2));

  // The count keeps running under a freeze; only the exception path clears it.
  div_timer #(.DIV_LAT(DIV_LAT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (exc_take),
    .load   (div_start),
    .count  (state == DIV),
    .freeze (d_stall),
    .zero   (zero),
    .park   (park)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else if (d_stall) begin
      if (park) state <= DIV_HOLD;
    end else if (m_exc) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (e_div) state <= DIV;
        DIV:      if (zero) state <= RUN;
        DIV_HOLD: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  always_comb begin
    ctl       = '0;
    ctl.en    = '1;
    ctl.flush = '0;
    div_done  = 1'b0;
    if (reset) begin
      ctl.en    = '0;
      ctl.flush = '1;
    end else if (d_stall) begin
      ctl.en = '0;
    end else if (m_exc) begin
      ctl.flush = '1;
    end else if (((state == DIV) && !zero) || ((state == RUN) && e_div)) begin
      ctl.en.f    = 1'b0;
      ctl.en.d    = 1'b0;
      ctl.en.e    = 1'b0;
      ctl.flush.m = 1'b1;
    end else if ((state == DIV) || (state == DIV_HOLD)) begin
      div_done = 1'b1;
    end else if (e_redirect) begin
      ctl.flush.d = 1'b1;
      ctl.flush.e = 1'b1;
    end else if (load_use) begin
      // D holds the consumer, so an overlapping i_stall must not bubble D.
      ctl.en.f    = 1'b0;
      ctl.en.d    = 1'b0;
      ctl.flush.e = 1'b1;
    end else if (i_stall) begin
      ctl.en.f    = 1'b0;
      ctl.flush.d = 1'b1;
    end
  end

  assign en_f    = ctl.en.f;
  assign en_d    = ctl.en.d;
  assign en_e    = ctl.en.e;
  assign en_m    = ctl.en.m;
  assign en_w    = ctl.en.w;
  assign flush_d = ctl.flush.d;
  assign flush_e = ctl.flush.e;
  assign flush_m = ctl.flush.m;
  assign flush_w = ctl.flush.w;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_stall, cnt_flush, cnt_div;
  logic             flush_act;

  assign flush_act = exc_take |
                     (~d_stall & (state == RUN) & ~e_div & e_redirect);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_stall <= '0;
      cnt_flush <= '0;
      cnt_div   <= '0;
    end else begin
      if (!ctl.en.d && (cnt_stall != '1)) cnt_stall <= cnt_stall + CNT_W'(1);
      if (flush_act && (cnt_flush != '1)) cnt_flush <= cnt_flush + CNT_W'(1);
      if ((state != RUN) && (cnt_div != '1)) cnt_div <= cnt_div + CNT_W'(1);
    end
  end

  assign perf_stall = cnt_stall;
  assign perf_flush = cnt_flush;
  assign perf_div   = cnt_div;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_div   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with DIV_LAT=4.
module tb_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  // ctl = {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e,flush_m,flush_w, div_done}
  localparam logic [9:0] C_DEF  = 10'b11111_0000_0;
  localparam logic [9:0] C_RST  = 10'b00000_1111_0;
  localparam logic [9:0] C_LU   = 10'b00111_0100_0;
  localparam logic [9:0] C_DIVS = 10'b00011_0010_0;
  localparam logic [9:0] C_REL  = 10'b11111_0000_1;
  localparam logic [9:0] C_FRZ  = 10'b00000_0000_0;
  localparam logic [9:0] C_EXC  = 10'b11111_1111_0;
  localparam logic [9:0] C_RDR  = 10'b11111_1100_0;
  localparam logic [9:0] C_IST  = 10'b01111_1000_0;

  logic clk = 1'b0;
  logic reset, i_stall, d_stall, d_valid, e_load, e_div, e_redirect, m_exc;
  logic [REG_W-1:0] d_rs1, d_rs2, e_rd;
  logic en_f, en_d, en_e, en_m, en_w;
  logic flush_d, flush_e, flush_m, flush_w, div_done;
  logic [CNT_W-1:0] perf_stall, perf_flush, perf_div;
  logic [9:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ctl = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, flush_w, div_done};

  hazard_ctrl #(.DIV_LAT(4), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .d_stall(d_stall),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .e_load(e_load),
    .e_rd(e_rd), .e_div(e_div), .e_redirect(e_redirect), .m_exc(m_exc),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .div_done(div_done), .perf_stall(perf_stall), .perf_flush(perf_flush),
    .perf_div(perf_div)
  );

  task automatic clr();
    reset = 1'b0; i_stall = 1'b0; d_stall = 1'b0; d_valid = 1'b0;
    e_load = 1'b0; e_div = 1'b0; e_redirect = 1'b0; m_exc = 1'b0;
    d_rs1 = '0; d_rs2 = '0; e_rd = '0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
    adv();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, C_DEF); end
    checks++;
    if ({perf_stall, perf_flush, perf_div} !== '0) begin
      errors++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_stall, perf_flush, perf_div);
    end
    adv();
  endtask

  task automatic test_load_use();
    clr(); e_load = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5; d_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); end
    adv();
    clr();
    @(negedge clk);
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL lu_one_bubble got=%b exp=%b", ctl, C_DEF); end
    adv();
    e_load = 1'b1; e_rd = 5'd0; d_rs1 = 5'd0; d_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", ctl, C_DEF); end
    adv();
    e_rd = 5'd7; d_rs1 = 5'd3; d_rs2 = 5'd7;
    @(negedge clk);
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
    adv();
    d_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL lu_dinvalid got=%b exp=%b", ctl, C_DEF); end
    adv();
    d_valid = 1'b1; i_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL lu_with_istall got=%b exp=%b", ctl, C_LU); end
    adv();
    clr();
  endtask

  task automatic test_redirect();
    clr(); e_redirect = 1'b1; i_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_RDR) begin errors++; $display("FAIL redirect_istall got=%b exp=%b", ctl, C_RDR); end
    adv();
    i_stall = 1'b0; e_load = 1'b1; e_rd = 5'd9; d_rs1 = 5'd9; d_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_RDR) begin errors++; $display("FAIL redirect_over_lu got=%b exp=%b", ctl, C_RDR); end
    adv();
    clr(); i_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_IST) begin errors++; $display("FAIL istall got=%b exp=%b", ctl, C_IST); end
    adv();
    clr();
  endtask

  task automatic test_divide();
    clr(); e_div = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_DIVS) begin errors++; $display("FAIL div_stall c%0d got=%b exp=%b", i, ctl, C_DIVS); end
      adv();
    end
    @(negedge clk);
    checks++;
    if (ctl !== C_REL) begin errors++; $display("FAIL div_release got=%b exp=%b", ctl, C_REL); end
    adv();
    e_div = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL div_after got=%b exp=%b", ctl, C_DEF); end
    adv();
  endtask

  task automatic test_div_freeze();
    clr(); e_div = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_DIVS) begin errors++; $display("FAIL dfrz_stall c%0d got=%b exp=%b", i, ctl, C_DIVS); end
      adv();
    end
    d_stall = 1'b1;
    for (int i = 2; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_FRZ) begin errors++; $display("FAIL dfrz_freeze c%0d got=%b exp=%b", i, ctl, C_FRZ); end
      adv();
    end
    d_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_REL) begin errors++; $display("FAIL dfrz_release got=%b exp=%b", ctl, C_REL); end
    adv();
    e_div = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_DEF) begin errors++; $display("FAIL dfrz_after got=%b exp=%b", ctl, C_DEF); end
    adv();
  endtask

  task automatic test_exception();
    clr(); e_div = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_DIVS) begin errors++; $display("FAIL exc_divstall c%0d got=%b exp=%b", i, ctl, C_DIVS); end
      adv();
    end
    m_exc = 1'b1; e_redirect = 1'b1; i_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_EXC) begin errors++; $display("FAIL exc_in_div got=%b exp=%b", ctl, C_EXC); end
    adv();
    clr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== C_DEF) begin errors++; $display("FAIL exc_abort c%0d got=%b exp=%b", i, ctl, C_DEF); end
      adv();
    end
  endtask

  task automatic test_freeze_precedence();
    clr(); d_stall = 1'b1; m_exc = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_FRZ) begin errors++; $display("FAIL frz_over_exc got=%b exp=%b", ctl, C_FRZ); end
    adv();
    d_stall = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_EXC) begin errors++; $display("FAIL exc_after_frz got=%b exp=%b", ctl, C_EXC); end
    adv();
    clr();
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] es1, ef1, ed1, es2, ef2, ed2;
`ifdef HAZARD_PERF_EN
    es1 = 3; ef1 = 1; ed1 = 0; es2 = 7; ef2 = 1; ed2 = 4;
`else
    es1 = 0; ef1 = 0; ed1 = 0; es2 = 0; ef2 = 0; ed2 = 0;
`endif
    clr(); reset = 1'b1;
    adv();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_load = 1'b1; e_rd = 5'd4; d_rs2 = 5'd4; d_valid = 1'b1;
      adv();
      clr();
      adv();
    end
    e_redirect = 1'b1;
    adv();
    clr();
    adv();
    @(negedge clk);
    checks++;
    if ({perf_stall, perf_flush, perf_div} !== {es1, ef1, ed1}) begin
      errors++; $display("FAIL perf_lu_rdr got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         perf_stall, perf_flush, perf_div, es1, ef1, ed1);
    end
    e_div = 1'b1;
    repeat (5) adv();
    clr();
    adv();
    @(negedge clk);
    checks++;
    if ({perf_stall, perf_flush, perf_div} !== {es2, ef2, ed2}) begin
      errors++; $display("FAIL perf_div got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         perf_stall, perf_flush, perf_div, es2, ef2, ed2);
    end
    reset = 1'b1;
    adv();
    @(negedge clk);
    checks++;
    if ({perf_stall, perf_flush, perf_div} !== '0) begin
      errors++; $display("FAIL perf_clear got=%0d/%0d/%0d exp=0/0/0", perf_stall, perf_flush, perf_div);
    end
    adv();
    clr();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_divide();
    test_div_freeze();
    test_exception();
    test_freeze_precedence();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
